// File: rtl/sync_frame_loader_pkg.sv
// Shared constants and types for the sync frame loader.
package sync_frame_loader_pkg;

    // Field index of each frame byte; also the error code for a failed field
    localparam logic [2:0] FLD_YEAR  = 3'd0;
    localparam logic [2:0] FLD_MONTH = 3'd1;
    localparam logic [2:0] FLD_DAY   = 3'd2;
    localparam logic [2:0] FLD_WDAY  = 3'd3;
    localparam logic [2:0] FLD_HOUR  = 3'd4;
    localparam logic [2:0] FLD_MIN   = 3'd5;
    localparam logic [2:0] FLD_SEC   = 3'd6;

    // Error code reported when a frame arrives while the loader is busy
    localparam logic [2:0] ERR_OVERRUN = 3'd7;

    // Per-field upper limits
    localparam logic [7:0] YEAR_MAX   = 8'd99;
    localparam logic [6:0] MONTH_MAX  = 7'd12;
    localparam logic [6:0] WDAY_MAX   = 7'd7;
    localparam logic [6:0] HOUR_MAX   = 7'd23;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCheck  = 2'd1,
        StCommit = 2'd2,
        StError  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_frame_loader_bcd2_to_bin.sv
// Two-digit BCD to binary converter with digit validity flag.
module bcd2_to_bin (
    input  logic [7:0] i_bcd,
    output logic [6:0] o_bin,
    output logic       o_nibble_ok
);

    logic [3:0] w_hi;
    logic [3:0] w_lo;

    assign w_hi = i_bcd[7:4];
    assign w_lo = i_bcd[3:0];

    // hi*10 + lo as hi*8 + hi*2 + lo; result is meaningless when a digit is invalid
    assign o_bin       = {w_hi, 3'b000} + {2'b00, w_hi, 1'b0} + {3'b000, w_lo};
    assign o_nibble_ok = (w_hi <= 4'd9) && (w_lo <= 4'd9);

endmodule

// File: rtl/sync_frame_loader.sv
// Captures a 56-bit sync frame, validates one field per cycle, and loads the
// converted time/date into the clock counters or reports why it was rejected.
module sync_frame_loader
    import sync_frame_loader_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_done,
    input  logic [55:0]          i_received_value,
    output logic                 o_load,
    output logic [5:0]           o_sec,
    output logic [5:0]           o_min,
    output logic [4:0]           o_hour,
    output logic [2:0]           o_wday,
    output logic [4:0]           o_day,
    output logic [3:0]           o_month,
    output logic [6:0]           o_year,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic [2:0]           o_err_code,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic [ERR_CNT_W-1:0] o_ok_count
);

    state_t               r_state;
    logic [55:0]          r_shadow;
    logic [2:0]           r_idx;
    logic                 r_load;
    logic                 r_frame_err;
    logic [2:0]           r_err_code;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [ERR_CNT_W-1:0] r_ok_count;
    logic [5:0]           r_sec;
    logic [5:0]           r_min;
    logic [4:0]           r_hour;
    logic [2:0]           r_wday;
    logic [4:0]           r_day;
    logic [3:0]           r_month;
    logic [6:0]           r_year;

    // Converted BCD bytes 1..6: [0]=month [1]=day [2]=wday [3]=hour [4]=min [5]=sec
    logic [6:0] w_bin    [6];
    logic       w_nib_ok [6];
    logic       w_field_ok;
    logic       w_fail;
    logic       w_overrun;

    function automatic logic [4:0] days_in_month(input logic [3:0] mon,
                                                 input logic [1:0] yr_lo);
        case (mon)
            4'd2:                    return (yr_lo == 2'b00) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    for (genvar g = 0; g < 6; g++) begin : g_bcd
        bcd2_to_bin u_bcd (
            .i_bcd       (r_shadow[8*(g+1) +: 8]),
            .o_bin       (w_bin[g]),
            .o_nibble_ok (w_nib_ok[g])
        );
    end

    // Validate the shadow field selected by r_idx; year and month are already
    // known good by the time the day check reads them
    always_comb begin
        w_field_ok = 1'b0;
        case (r_idx)
            FLD_YEAR:  w_field_ok = (r_shadow[7:0] <= YEAR_MAX);
            FLD_MONTH: w_field_ok = w_nib_ok[0] && (w_bin[0] != 7'd0) && (w_bin[0] <= MONTH_MAX);
            FLD_DAY:   w_field_ok = w_nib_ok[1] && (w_bin[1] != 7'd0) &&
                           (w_bin[1] <= {2'b00, days_in_month(w_bin[0][3:0], r_shadow[1:0])});
            FLD_WDAY:  w_field_ok = w_nib_ok[2] && (w_bin[2] != 7'd0) && (w_bin[2] <= WDAY_MAX);
            FLD_HOUR:  w_field_ok = w_nib_ok[3] && (w_bin[3] <= HOUR_MAX);
            FLD_MIN:   w_field_ok = w_nib_ok[4] && (w_bin[4] <= MINSEC_MAX);
            FLD_SEC:   w_field_ok = w_nib_ok[5] && (w_bin[5] <= MINSEC_MAX);
            default:   w_field_ok = 1'b0;
        endcase
    end

    assign w_fail    = (r_state == StCheck) && !w_field_ok;
    assign w_overrun = (r_state != StIdle) && i_rx_done;

    // Frame FSM with registered pulses, outputs and counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= '0;
            r_err_count <= '0;
            r_ok_count  <= '0;
            r_sec       <= '0;
            r_min       <= '0;
            r_hour      <= '0;
            r_wday      <= '0;
            r_day       <= '0;
            r_month     <= '0;
            r_year      <= '0;
        end else begin
            r_load      <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_rx_done) begin
                        r_shadow <= i_received_value;
                        r_idx    <= FLD_YEAR;
                        r_state  <= StCheck;
                    end
                end
                StCheck: begin
                    if (!w_field_ok) begin
                        r_state <= StError;
                    end else if (r_idx == FLD_SEC) begin
                        // Outputs are registered here so they are valid during the COMMIT cycle
                        r_state <= StCommit;
                        r_load  <= 1'b1;
                        r_year  <= r_shadow[6:0];
                        r_month <= w_bin[0][3:0];
                        r_day   <= w_bin[1][4:0];
                        r_wday  <= w_bin[2][2:0];
                        r_hour  <= w_bin[3][4:0];
                        r_min   <= w_bin[4][5:0];
                        r_sec   <= w_bin[5][5:0];
                        if (r_ok_count != '1) begin
                            r_ok_count <= r_ok_count + 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                StCommit: r_state <= StIdle;
                StError:  r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
            // A field failure and an overrun in the same cycle merge into one pulse
            if (w_fail || w_overrun) begin
                r_frame_err <= 1'b1;
                r_err_code  <= w_overrun ? ERR_OVERRUN : r_idx;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign o_load      = r_load;
    assign o_sec       = r_sec;
    assign o_min       = r_min;
    assign o_hour      = r_hour;
    assign o_wday      = r_wday;
    assign o_day       = r_day;
    assign o_month     = r_month;
    assign o_year      = r_year;
    assign o_busy      = (r_state != StIdle);
    assign o_frame_err = r_frame_err;
    assign o_err_code  = r_err_code;
    assign o_err_count = r_err_count;
    assign o_ok_count  = r_ok_count;

endmodule

// File: tb/tb_sync_frame_loader.sv
// Randomized bench for sync_frame_loader against a cycle-event reference model.
module tb_sync_frame_loader;

    logic        clk;
    logic        i_reset;
    logic        i_rx_done;
    logic [55:0] i_received_value;
    logic        o_load;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic [4:0]  o_hour;
    logic [2:0]  o_wday;
    logic [4:0]  o_day;
    logic [3:0]  o_month;
    logic [6:0]  o_year;
    logic        o_busy;
    logic        o_frame_err;
    logic [2:0]  o_err_code;
    logic [7:0]  o_err_count;
    logic [7:0]  o_ok_count;

    sync_frame_loader #(.ERR_CNT_W(8)) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_rx_done        (i_rx_done),
        .i_received_value (i_received_value),
        .o_load           (o_load),
        .o_sec            (o_sec),
        .o_min            (o_min),
        .o_hour           (o_hour),
        .o_wday           (o_wday),
        .o_day            (o_day),
        .o_month          (o_month),
        .o_year           (o_year),
        .o_busy           (o_busy),
        .o_frame_err      (o_frame_err),
        .o_err_code       (o_err_code),
        .o_err_count      (o_err_count),
        .o_ok_count       (o_ok_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: expected events keyed by the cycle they become visible
    int cyc       = 0;
    bit armed     = 0;
    int busy_from = 1;
    int busy_to   = 0;
    int ld_cycle  = -1;
    int ev_code [int];
    int ld_year, ld_month, ld_day, ld_wday, ld_hour, ld_min, ld_sec;
    int m_year, m_month, m_day, m_wday, m_hour, m_min, m_sec;
    int m_code, m_errc, m_okc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int bcd_val(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r = 8'(((n / 10) << 4) | (n % 10));
        return r;
    endfunction

    // Index of the first invalid field, or -1 when the whole frame is good
    function automatic int first_fail(input logic [55:0] v);
        int yr, mo, dim;
        yr = int'(v[7:0]);
        if (yr > 99) return 0;
        mo = bcd_val(v[15:8]);
        if (!bcd_ok(v[15:8]) || mo < 1 || mo > 12) return 1;
        if (mo == 2) dim = (yr % 4 == 0) ? 29 : 28;
        else if (mo == 4 || mo == 6 || mo == 9 || mo == 11) dim = 30;
        else dim = 31;
        if (!bcd_ok(v[23:16]) || bcd_val(v[23:16]) < 1 || bcd_val(v[23:16]) > dim) return 2;
        if (!bcd_ok(v[31:24]) || bcd_val(v[31:24]) < 1 || bcd_val(v[31:24]) > 7) return 3;
        if (!bcd_ok(v[39:32]) || bcd_val(v[39:32]) > 23) return 4;
        if (!bcd_ok(v[47:40]) || bcd_val(v[47:40]) > 59) return 5;
        if (!bcd_ok(v[55:48]) || bcd_val(v[55:48]) > 59) return 6;
        return -1;
    endfunction

    function automatic logic [55:0] gen_frame();
        logic [55:0] f;
        int k;
        f = {to_bcd($urandom_range(0, 59)), to_bcd($urandom_range(0, 59)),
             to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(1, 7)),
             to_bcd($urandom_range(1, 31)), to_bcd($urandom_range(1, 12)),
             8'($urandom_range(0, 99))};
        if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, 6);
            f[8*k +: 8] = 8'($urandom);
        end
        return f;
    endfunction

    task automatic check_cycle();
        bit e_load, e_ferr, e_busy;
        e_load = 0;
        e_ferr = 0;
        if (cyc == ld_cycle) begin
            e_load = 1;
            m_year = ld_year;  m_month = ld_month; m_day = ld_day; m_wday = ld_wday;
            m_hour = ld_hour;  m_min = ld_min;     m_sec = ld_sec;
            if (m_okc < 255) m_okc++;
            ld_cycle = -1;
        end
        if (ev_code.exists(cyc)) begin
            e_ferr = 1;
            m_code = ev_code[cyc];
            ev_code.delete(cyc);
            if (m_errc < 255) m_errc++;
        end
        e_busy = (cyc >= busy_from) && (cyc <= busy_to);
        if (!armed) return;
        check_val("load", o_load, e_load);
        check_val("frame_err", o_frame_err, e_ferr);
        check_val("busy", o_busy, e_busy);
        check_val("err_code", o_err_code, m_code);
        check_val("err_count", o_err_count, m_errc);
        check_val("ok_count", o_ok_count, m_okc);
        check_val("year", o_year, m_year);
        check_val("month", o_month, m_month);
        check_val("day", o_day, m_day);
        check_val("wday", o_wday, m_wday);
        check_val("hour", o_hour, m_hour);
        check_val("min", o_min, m_min);
        check_val("sec", o_sec, m_sec);
    endtask

    task automatic model_drive(input bit rst, input bit rx, input logic [55:0] v);
        int k;
        if (rst) begin
            armed = 1;
            ev_code.delete();
            ld_cycle = -1;
            busy_from = 1;
            busy_to = 0;
            m_year = 0; m_month = 0; m_day = 0; m_wday = 0; m_hour = 0; m_min = 0; m_sec = 0;
            m_code = 0; m_errc = 0; m_okc = 0;
        end else if (rx) begin
            if (cyc >= busy_from && cyc <= busy_to) begin
                ev_code[cyc + 1] = 7;
            end else begin
                k = first_fail(v);
                busy_from = cyc + 1;
                if (k < 0) begin
                    busy_to  = cyc + 8;
                    ld_cycle = cyc + 8;
                    ld_year  = int'(v[7:0]);
                    ld_month = bcd_val(v[15:8]);
                    ld_day   = bcd_val(v[23:16]);
                    ld_wday  = bcd_val(v[31:24]);
                    ld_hour  = bcd_val(v[39:32]);
                    ld_min   = bcd_val(v[47:40]);
                    ld_sec   = bcd_val(v[55:48]);
                end else begin
                    busy_to = cyc + k + 2;
                    ev_code[cyc + k + 2] = k;
                end
            end
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then drive this cycle's inputs
    task automatic step(input bit rst, input bit rx, input logic [55:0] v);
        @(negedge clk);
        check_cycle();
        i_reset = rst;
        i_rx_done = rx;
        i_received_value = v;
        model_drive(rst, rx, v);
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0);
    endtask

    logic [55:0] f1, f2, f3, f4;

    initial begin
        i_reset = 1'b1;
        i_rx_done = 1'b0;
        i_received_value = '0;
        f1 = {8'h07, 8'h45, 8'h13, 8'h04, 8'h29, 8'h02, 8'd24};
        f2 = {8'h00, 8'h00, 8'h00, 8'h01, 8'h29, 8'h02, 8'd23};
        f3 = {8'h5A, 8'h45, 8'h13, 8'h04, 8'h29, 8'h02, 8'd24};
        f4 = {8'h07, 8'h45, 8'h13, 8'h04, 8'h01, 8'h13, 8'd24};

        step(1, 0, '0);
        step(1, 0, '0);
        #1;
        check_val("reset_busy", o_busy, 0);
        check_val("reset_err_count", o_err_count, 0);

        // Leap-year Feb 29 loads eight cycles after rx_done
        step(0, 1, f1);
        idle(7);
        #1;
        check_val("t1_load", o_load, 1);
        check_val("t1_year", o_year, 24);
        check_val("t1_month", o_month, 2);
        check_val("t1_day", o_day, 29);
        check_val("t1_wday", o_wday, 4);
        check_val("t1_hour", o_hour, 13);
        check_val("t1_min", o_min, 45);
        check_val("t1_sec", o_sec, 7);
        check_val("t1_ok_count", o_ok_count, 1);
        idle(2);

        // Non-leap Feb 29 fails the day field
        step(0, 1, f2);
        idle(3);
        #1;
        check_val("t2_frame_err", o_frame_err, 1);
        check_val("t2_err_code", o_err_code, 2);
        check_val("t2_day_held", o_day, 29);
        idle(2);

        // Bad BCD seconds, then month 13
        step(0, 1, f3);
        idle(7);
        #1;
        check_val("t3_frame_err", o_frame_err, 1);
        check_val("t3_err_code", o_err_code, 6);
        check_val("t3_no_load", o_load, 0);
        idle(2);
        step(0, 1, f4);
        idle(2);
        #1;
        check_val("t4_frame_err", o_frame_err, 1);
        check_val("t4_err_code", o_err_code, 1);
        idle(2);

        // Overrun during CHECK
        step(1, 0, '0);
        step(1, 0, '0);
        step(0, 1, f1);
        idle(2);
        step(0, 1, f3);
        #1;
        check_val("ovr_frame_err", o_frame_err, 1);
        check_val("ovr_err_code", o_err_code, 7);
        idle(4);
        #1;
        check_val("ovr_load", o_load, 1);
        check_val("ovr_ok_count", o_ok_count, 1);
        check_val("ovr_err_count", o_err_count, 1);
        idle(2);

        // Reset in the middle of CHECK
        step(0, 1, f1);
        idle(4);
        step(1, 0, '0);
        #1;
        check_val("mid_rst_busy", o_busy, 0);
        check_val("mid_rst_ok_count", o_ok_count, 0);
        check_val("mid_rst_err_count", o_err_count, 0);
        check_val("mid_rst_year", o_year, 0);
        idle(6);

        repeat (3000) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, gen_frame());
        end
        idle(10);

        // Error counter saturation
        step(1, 0, '0);
        step(1, 0, '0);
        repeat (260) begin
            step(0, 1, 56'hFF);
            idle(2);
        end
        idle(2);
        #1;
        check_val("sat_err_count", o_err_count, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
